// File: rtl/max_pool_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : max_pool_stream
// Brief    : 2x2 / stride-2 streaming max-pool with optional ReLU, raster in
//            and raster out, using a half-row line buffer of horizontal maxima.
// Revision : 1.0  initial release
// ============================================================================
module max_pool_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_SIZE    = 24,
    parameter int RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  frame_done
);

    localparam int              c_CW   = (IN_SIZE > 2) ? $clog2(IN_SIZE) : 1;
    localparam int              c_HALF = IN_SIZE / 2;
    localparam int              c_AW   = (c_HALF > 1) ? $clog2(c_HALF) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(IN_SIZE - 1);

    logic [c_CW-1:0]       r_col_q,        w_col_d;
    logic [c_CW-1:0]       r_row_q,        w_row_d;
    logic [DATA_WIDTH-1:0] r_pair_q,       w_pair_d;
    logic                  r_out_valid_q,  w_out_valid_d;
    logic [DATA_WIDTH-1:0] r_out_data_q,   w_out_data_d;
    logic                  r_frame_done_q, w_frame_done_d;

    logic [DATA_WIDTH-1:0] r_linebuf_q [c_HALF];

    logic [c_AW-1:0]       w_lb_addr;
    logic                  w_lb_we;
    logic [DATA_WIDTH-1:0] w_lb_rd;
    logic [DATA_WIDTH-1:0] w_hmax;
    logic [DATA_WIDTH-1:0] w_res;

    always_comb begin
        w_col_d        = r_col_q;
        w_row_d        = r_row_q;
        w_pair_d       = r_pair_q;
        w_out_valid_d  = 1'b0;
        w_out_data_d   = r_out_data_q;
        w_frame_done_d = 1'b0;
        w_lb_we        = 1'b0;
        w_lb_addr      = c_AW'(r_col_q >> 1);
        w_lb_rd        = r_linebuf_q[w_lb_addr];

        w_hmax = ($signed(r_pair_q) > $signed(in_data)) ? r_pair_q : in_data;
        w_res  = ($signed(w_lb_rd) > $signed(w_hmax)) ? w_lb_rd : w_hmax;
        if ((RELU_EN != 0) && w_res[DATA_WIDTH-1]) begin
            w_res = '0;
        end

        if (in_valid) begin
            if (r_col_q == c_LAST) begin
                w_col_d = '0;
                w_row_d = (r_row_q == c_LAST) ? '0 : r_row_q + 1'b1;
            end else begin
                w_col_d = r_col_q + 1'b1;
            end

            // Even rows park the horizontal max; odd rows close the window.
            if (!r_col_q[0]) begin
                w_pair_d = in_data;
            end else if (!r_row_q[0]) begin
                w_lb_we = 1'b1;
            end else begin
                w_out_valid_d  = 1'b1;
                w_out_data_d   = w_res;
                w_frame_done_d = (r_row_q == c_LAST) && (r_col_q == c_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_q        <= '0;
            r_row_q        <= '0;
            r_pair_q       <= '0;
            r_out_valid_q  <= 1'b0;
            r_out_data_q   <= '0;
            r_frame_done_q <= 1'b0;
        end else begin
            r_col_q        <= w_col_d;
            r_row_q        <= w_row_d;
            r_pair_q       <= w_pair_d;
            r_out_valid_q  <= w_out_valid_d;
            r_out_data_q   <= w_out_data_d;
            r_frame_done_q <= w_frame_done_d;
        end
    end

    // Contents need no reset: every entry is written on an even row before
    // the odd row reads it.
    always_ff @(posedge clk) begin
        if (w_lb_we) begin
            r_linebuf_q[w_lb_addr] <= w_hmax;
        end
    end

    assign out_valid  = r_out_valid_q;
    assign out_data   = r_out_data_q;
    assign frame_done = r_frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_max_pool_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_max_pool_stream
// Brief    : Directed bench for max_pool_stream; three instances cover
//            4x4 ReLU, 4x4 signed pass-through and 24x24 ReLU configurations.
// Revision : 1.0  initial release
// ============================================================================
module tb_max_pool_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_v [3];
    logic [15:0] in_d [3];
    logic        ov   [3];
    logic [15:0] od   [3];
    logic        fd   [3];

    always #5 clk = ~clk;

    max_pool_stream #(.DATA_WIDTH(16), .IN_SIZE(4), .RELU_EN(1)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_v[0]), .in_data(in_d[0]),
        .out_valid(ov[0]), .out_data(od[0]), .frame_done(fd[0]));
    max_pool_stream #(.DATA_WIDTH(16), .IN_SIZE(4), .RELU_EN(0)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_v[1]), .in_data(in_d[1]),
        .out_valid(ov[1]), .out_data(od[1]), .frame_done(fd[1]));
    max_pool_stream #(.DATA_WIDTH(16), .IN_SIZE(24), .RELU_EN(1)) u_c (
        .clk(clk), .reset(reset), .in_valid(in_v[2]), .in_data(in_d[2]),
        .out_valid(ov[2]), .out_data(od[2]), .frame_done(fd[2]));

    typedef struct {
        int          sel;
        logic [15:0] data;
        logic        fdone;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          mon_en = 1'b0;
    int          mr [3];
    int          mc [3];
    int          sz   [3] = '{4, 4, 24};
    int          relu [3] = '{1, 0, 1};
    logic [15:0] img  [3][24][24];
    logic [15:0] last [3];
    int          outcnt [3];
    int          fdcnt  [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one accepted beat and let the reference model predict any output.
    task automatic beat(input int s, input logic [15:0] d);
        exp_t        e;
        logic [15:0] m;
        int          r;
        int          c;
        in_v[s] = 1'b1;
        in_d[s] = d;
        @(posedge clk);
        #1;
        in_v[s] = 1'b0;
        r = mr[s];
        c = mc[s];
        img[s][r][c] = d;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            m = smax(smax(img[s][r-1][c-1], img[s][r-1][c]), smax(img[s][r][c-1], d));
            if (relu[s] != 0 && m[15]) m = 16'h0000;
            e.sel   = s;
            e.data  = m;
            e.fdone = (r == sz[s] - 1) && (c == sz[s] - 1);
            e.cyc   = cyc;
            sb.push_back(e);
        end
        if (c == sz[s] - 1) begin
            mc[s] = 0;
            mr[s] = (r == sz[s] - 1) ? 0 : r + 1;
        end else begin
            mc[s] = c + 1;
        end
    endtask

    task automatic do_reset(input bit with_beat);
        reset = 1'b1;
        if (with_beat) begin
            in_v[0] = 1'b1;
            in_d[0] = 16'h7777;
        end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        in_v[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mr[i]   = 0;
            mc[i]   = 0;
            last[i] = 16'h0000;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                if (ov[i] === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("unexpected_output%0d", i), 32'(sb.size()), 32'd1);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk($sformatf("out_inst%0d", i), 32'(i), 32'(e.sel));
                        chk($sformatf("out_data%0d", i), 32'(od[i]), 32'(e.data));
                        chk($sformatf("frame_done%0d", i), 32'(fd[i]), 32'(e.fdone));
                        chk($sformatf("latency_cyc%0d", i), 32'(cyc), 32'(e.cyc));
                    end
                    last[i] = od[i];
                    outcnt[i]++;
                    if (fd[i] === 1'b1) fdcnt[i]++;
                end else begin
                    chk($sformatf("hold_data%0d", i), 32'(od[i]), 32'(last[i]));
                    chk($sformatf("idle_frame_done%0d", i), 32'(fd[i]), 32'd0);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_v[i]   = 1'b0;
            in_d[i]   = 16'h0000;
            outcnt[i] = 0;
            fdcnt[i]  = 0;
        end
        idle(2);
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out_valid%0d", i), 32'(ov[i]), 32'd0);
            chk($sformatf("rst_out_data%0d", i), 32'(od[i]), 32'd0);
            chk($sformatf("rst_frame_done%0d", i), 32'(fd[i]), 32'd0);
        end
        mon_en = 1'b1;

        // Contiguous ramp
        for (int i = 0; i < 16; i++) beat(0, 16'(i));
        idle(2);

        // All -3, ReLU and pass-through
        for (int i = 0; i < 16; i++) beat(0, 16'hFFFD);
        for (int i = 0; i < 16; i++) beat(1, 16'hFFFD);
        idle(2);

        // Ramp with random gaps
        for (int i = 0; i < 16; i++) begin
            beat(0, 16'(i));
            idle($urandom_range(0, 3));
        end
        idle(2);

        // Mid-frame reset, with a colliding beat that must be ignored
        for (int i = 0; i < 9; i++) beat(0, 16'(3 * i + 1));
        do_reset(1'b1);
        chk("midrst_out_valid", 32'(ov[0]), 32'd0);
        chk("midrst_out_data", 32'(od[0]), 32'd0);
        for (int i = 0; i < 16; i++) beat(0, 16'(100 + i));
        idle(2);

        // Extremes of the signed range
        begin
            logic [15:0] f [16];
            f = '{16'h8000, 16'h8000, 16'h7FFF, 16'h8000,
                  16'h8000, 16'h8001, 16'h8000, 16'h8000,
                  16'h8000, 16'h8000, 16'h8000, 16'h8000,
                  16'h8000, 16'h8000, 16'h8000, 16'h7FFF};
            for (int i = 0; i < 16; i++) beat(1, f[i]);
        end
        idle(2);

        // Two back-to-back 24x24 frames
        for (int fr = 0; fr < 2; fr++)
            for (int r = 0; r < 24; r++)
                for (int c = 0; c < 24; c++)
                    beat(2, 16'(r * 24 + c));
        idle(4);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("count_out_a", 32'(outcnt[0]), 32'd18);
        chk("count_out_b", 32'(outcnt[1]), 32'd8);
        chk("count_out_c", 32'(outcnt[2]), 32'd288);
        chk("count_fd_a", 32'(fdcnt[0]), 32'd4);
        chk("count_fd_b", 32'(fdcnt[1]), 32'd2);
        chk("count_fd_c", 32'(fdcnt[2]), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
